eeprom_i2c_ctrl: RTL and testbench
==================================

Name: eeprom_i2c_ctrl

Overview:
- I2C (two-wire) master that moves one 32-bit word between the host logic and a 24Cxx-style serial EEPROM on the board.
- Host sets the device control byte, pulses `req`, and waits for the `ack` completion pulse.
- `ctrl_byte` bit0 selects the direction: 0 is a 4-byte page write from `data_in`, 1 is a 4-byte random read into `data_out`.
- Sits between the user logic and the EEPROM pins `scl`/`sda`.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SCL_FREQ, 400_000, SCL frequency in Hz. Quarter-period divider QDIV = CLK_FREQ/(4*SCL_FREQ), truncated, minimum 1.
- WORD_ADDR, 8'h00, EEPROM word address used by every transaction.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- scl, output, 1, I2C clock. Driven 1/0, idles 1.
- sda, inout, 1, I2C data. Open-drain: driven 0 or released to Z. The board supplies the pull-up; the bench uses a pullup.
- ctrl_byte, input, 8, device address byte. Bits[7:1] are the device address; bit0 is 0 for write, 1 for read.
- data_in, input, 32, write data. Sent MSB byte first.
- data_out, output, 32, read data. The first byte received lands in [31:24].
- req, input, 1, start request. Level or pulse; sampled each clk.
- ack, output, 1, one-clk completion pulse.
- busy, output, 1, high while a transaction is in progress.

Behaviour:
- Reset state: scl=1, sda=Z, ack=0, busy=0, data_out=0, FSM in IDLE, divider cleared. Reset asserted mid-transfer aborts immediately to this state. No STOP is generated.
- Accept rule:
  - In IDLE, req=1 on a clk edge latches ctrl_byte and data_in, sets busy=1 on the next cycle, and starts the transaction.
  - req while busy=1 is ignored.
  - A req held high after completion restarts a new transaction.
- Bit timing: each SCL bit has 4 phases of QDIV clks each.
  - SDA changes only in the phase where SCL=0.
  - Sampling happens at the middle of the SCL-high time.
  - START: SDA falls while SCL is high. Repeated START works the same way.
  - STOP: SDA rises while SCL is high.
- States: IDLE, START, SEND_DEV, SEND_ADDR, WR_DATA, RESTART, SEND_DEVR, RD_DATA, STOP, DONE.
- Byte transfers are MSB first, 8 bits followed by a 9th ACK bit.
  - When sending, the master releases SDA in the 9th bit and samples the slave ACK (0 = ACK).
  - When receiving, the master drives its ACK/NACK in the 9th bit.
- Write sequence (bit0=0):
  - START, then {ctrl[7:1],0} with ACK, then WORD_ADDR with ACK.
  - Then data_in[31:24], [23:16], [15:8], [7:0], each with ACK.
  - Then STOP, DONE.
- Read sequence (bit0=1):
  - START, then {ctrl[7:1],0} with ACK, then WORD_ADDR with ACK.
  - RESTART, then {ctrl[7:1],1} with ACK.
  - Read 4 bytes: master ACK (SDA=0) after bytes 1-3, NACK (SDA released) after byte 4.
  - Then STOP, DONE.
- data_out updates only in DONE of a read, all 32 bits at once. It holds its value otherwise.
- DONE: ack=1 for exactly one clk and busy=0 in the same cycle. Return to IDLE.
- Slave NACK on any master-sent byte: go to STOP, then DONE (ack still pulses). data_out is unchanged; this is modified by the optional feature.
- Bus is idle (scl=1, sda=Z) whenever busy=0.

Optional Feature:
- Macro: EEPROM_I2C_CTRL_ACK_POLL_EN.
- Defined: a NACK on the first device-address byte issues STOP, then a new START and resends that byte. This covers the EEPROM internal write cycle. Retries are unbounded until ACK; busy stays high throughout. NACK on any other byte behaves as in the base design.
- Not defined: every NACK ends the transaction as in Behaviour.

Test Plan:
- Reset: assert rst mid-write byte → scl=1, sda=Z, busy=0, ack=0, data_out=0 within one clk.
- Write: ctrl_byte=8'hA6, data_in=32'h12345678, req for 3 clks → bus shows A6, 00, 12, 34, 56, 78, then STOP. ack is a single pulse, busy=0 afterwards, bytes are stored in the EEPROM model.
- Read: after the write, ctrl_byte=8'hA7, req pulse → bus shows A6, 00, repeated START, A7, 4 reads with ACK,ACK,ACK,NACK. data_out=32'h12345678 at the ack pulse.
- req while busy: pulse req again mid-transfer → ignored, exactly one ack.
- No slave: sda left pulled up, write request → NACK on the device byte, STOP, ack pulse, data_out unchanged (macro undefined). With the macro defined, START repeats and busy stays 1.
- Timing: SCL high and low times are each 2*QDIV clks (62 at the defaults). SDA is stable while SCL is high, except at START and STOP.

Source files
------------

// File: rtl/eeprom_i2c_ctrl.sv
// eeprom_i2c_ctrl: I2C master moving one 32-bit word to/from a 24Cxx EEPROM.
// Define EEPROM_I2C_CTRL_ACK_POLL_EN to retry a NACKed device-address byte until ACK.
module eeprom_i2c_ctrl #(
   parameter int         CLK_FREQ  = 50_000_000,
   parameter int         SCL_FREQ  = 400_000,
   parameter logic [7:0] WORD_ADDR = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   output logic        scl,
   inout  wire         sda,
   input  logic [7:0]  ctrl_byte,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        req,
   output logic        ack,
   output logic        busy
);
   localparam int QDIV_RAW = CLK_FREQ / (4 * SCL_FREQ);
   localparam int QDIV = QDIV_RAW < 1 ? 1 : QDIV_RAW;
   localparam int DW = QDIV < 2 ? 1 : $clog2(QDIV);
   localparam logic [DW-1:0] DIV_END = DW'(QDIV - 1);
`ifdef EEPROM_I2C_CTRL_ACK_POLL_EN
   localparam logic POLL = 1'b1;
`else
   localparam logic POLL = 1'b0;
`endif
   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] START     = 4'd1;
   localparam logic [3:0] SEND_DEV  = 4'd2;
   localparam logic [3:0] SEND_ADDR = 4'd3;
   localparam logic [3:0] WR_DATA   = 4'd4;
   localparam logic [3:0] RESTART   = 4'd5;
   localparam logic [3:0] SEND_DEVR = 4'd6;
   localparam logic [3:0] RD_DATA   = 4'd7;
   localparam logic [3:0] STOP      = 4'd8;
   localparam logic [3:0] DONE      = 4'd9;

   logic [3:0]    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    phase_q, phase_d;
   logic [3:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [7:0]    tx_q, tx_d, ctrl_q, ctrl_d;
   logic [31:0]   data_q, data_d, rx_q, rx_d, dout_q, dout_d;
   logic          nack_q, nack_d, retry_q, retry_d, rd_ok_q, rd_ok_d;
   logic          scl_q, scl_d, sda_q, sda_d;
   logic          tick, slot_end, sample, sending;

   assign tick     = div_q == DIV_END;
   assign slot_end = tick && phase_q == 2'd3;
   assign sample   = tick && phase_q == 2'd2;
   assign sending  = state_q inside {SEND_DEV, SEND_ADDR, WR_DATA, SEND_DEVR};
   assign scl      = scl_q;
   assign sda      = sda_q ? 1'bz : 1'b0;
   assign data_out = dout_q;
   assign ack      = state_q == DONE;
   assign busy     = state_q != IDLE && state_q != DONE;

   always_comb begin
      state_d = state_q;
      div_d   = '0;
      phase_d = '0;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      nack_d  = nack_q;
      retry_d = retry_q;
      rd_ok_d = rd_ok_q;
      if (busy) begin
         div_d   = tick ? '0 : div_q + 1'b1;
         phase_d = tick ? phase_q + 2'd1 : phase_q;
      end
      if (sample && sending && bit_q == 4'd8) nack_d = sda;
      if (sample && state_q == RD_DATA && bit_q != 4'd8) rx_d = {rx_q[30:0], sda};
      case (state_q)
         IDLE: if (req) begin
            state_d = START;
            ctrl_d  = ctrl_byte;
            data_d  = data_in;
            retry_d = 1'b0;
            rd_ok_d = 1'b0;
         end
         START: if (slot_end) begin
            state_d = SEND_DEV;
            tx_d    = {ctrl_q[7:1], 1'b0};
            bit_d   = '0;
            retry_d = 1'b0;
         end
         SEND_DEV, SEND_ADDR, WR_DATA, SEND_DEVR: if (slot_end) begin
            bit_d = bit_q == 4'd8 ? 4'd0 : bit_q + 4'd1;
            tx_d  = {tx_q[6:0], 1'b0};
            if (bit_q == 4'd8) begin
               // only the very first device byte is worth polling: EEPROM busy in its write cycle
               if (nack_q) begin
                  state_d = STOP;
                  retry_d = POLL && state_q == SEND_DEV;
               end else if (state_q == SEND_DEV) begin
                  state_d = SEND_ADDR;
                  tx_d    = WORD_ADDR;
               end else if (state_q == SEND_ADDR) begin
                  state_d = ctrl_q[0] ? RESTART : WR_DATA;
                  tx_d    = data_q[31:24];
                  byte_d  = '0;
               end else if (state_q == SEND_DEVR) begin
                  state_d = RD_DATA;
                  byte_d  = '0;
               end else if (byte_q == 2'd3) begin
                  state_d = STOP;
               end else begin
                  tx_d   = data_q[23:16];
                  data_d = {data_q[23:0], 8'h00};
                  byte_d = byte_q + 2'd1;
               end
            end
         end
         RESTART: if (slot_end) begin
            state_d = SEND_DEVR;
            tx_d    = {ctrl_q[7:1], 1'b1};
            bit_d   = '0;
         end
         RD_DATA: if (slot_end) begin
            bit_d = bit_q == 4'd8 ? 4'd0 : bit_q + 4'd1;
            if (bit_q == 4'd8) begin
               state_d = byte_q == 2'd3 ? STOP : RD_DATA;
               rd_ok_d = byte_q == 2'd3;
               byte_d  = byte_q + 2'd1;
            end
         end
         STOP: if (slot_end) begin
            state_d = retry_q ? START : DONE;
            dout_d  = !retry_q && rd_ok_q ? rx_q : dout_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pins are registered one clk behind the phase engine; phase 0 holds SDA so it only moves with SCL low.
   always_comb begin
      scl_d = 1'b1;
      sda_d = 1'b1;
      case (state_q)
         START: sda_d = phase_q != 2'd3;
         RESTART: begin
            scl_d = phase_q[1];
            sda_d = phase_q == 2'd0 ? sda_q : phase_q != 2'd3;
         end
         STOP: begin
            scl_d = phase_q[1];
            sda_d = phase_q == 2'd0 ? sda_q : phase_q == 2'd3;
         end
         SEND_DEV, SEND_ADDR, WR_DATA, SEND_DEVR: begin
            scl_d = phase_q[1];
            sda_d = phase_q == 2'd0 ? sda_q : bit_q == 4'd8 || tx_q[7];
         end
         RD_DATA: begin
            scl_d = phase_q[1];
            sda_d = phase_q == 2'd0 ? sda_q : bit_q != 4'd8 || byte_q == 2'd3;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         phase_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         tx_q    <= '0;
         ctrl_q  <= '0;
         data_q  <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         nack_q  <= 1'b0;
         retry_q <= 1'b0;
         rd_ok_q <= 1'b0;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         nack_q  <= nack_d;
         retry_q <= retry_d;
         rd_ok_q <= rd_ok_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
      end
   end
endmodule

// File: tb/tb_eeprom_i2c_ctrl.sv
// tb_eeprom_i2c_ctrl: directed bench with a behavioural 24Cxx slave and a bus trace.
module tb_eeprom_i2c_ctrl;
   localparam logic [31:0] TS = 32'h300;
   localparam logic [31:0] TP = 32'h301;
   logic        clk = 0, rst = 1, req = 0, scl, ack, busy;
   logic [7:0]  ctrl_byte = 8'h00;
   logic [31:0] data_in = 32'h0, data_out;
   wire         sda_w;
   logic        s_drv = 0;
   pullup (sda_w);
   assign sda_w = s_drv ? 1'b0 : 1'bz;

   eeprom_i2c_ctrl dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda_w), .ctrl_byte(ctrl_byte),
      .data_in(data_in), .data_out(data_out), .req(req), .ack(ack), .busy(busy)
   );

   always #10 clk = ~clk;

   int n_chk = 0, n_pass = 0, ack_cnt = 0;
   logic [31:0] trace[$], exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] bt(input logic [7:0] b);
      return {24'h000001, b};
   endfunction
   function automatic logic [31:0] ak(input logic a);
      return {31'h100, a};
   endfunction

   always @(posedge clk) if (ack) ack_cnt++;

   // EEPROM model at device address 7'h53; logs START/STOP, bytes and ack bits as seen on the bus
   logic [7:0] mem [0:255];
   logic [7:0] s_sh = 0, s_tx = 0, s_ptr = 0;
   logic       s_on = 0, s_rd = 0, s_pend = 0, present = 1, scl_p = 1, sda_p = 1;
   int         s_bits = 0, s_nbyte = 0;
   initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   always @(scl or sda_w) begin
      if (scl && scl_p && sda_p && !sda_w) begin
         trace.push_back(TS);
         s_bits = 0; s_nbyte = 0; s_rd = 0; s_pend = 0; s_drv = 0;
      end else if (scl && scl_p && !sda_p && sda_w) begin
         trace.push_back(TP);
         s_rd = 0; s_pend = 0; s_drv = 0;
      end else if (scl && !scl_p) begin
         s_bits++;
         if (s_bits <= 8) s_sh = {s_sh[6:0], sda_w};
         if (s_bits == 8) trace.push_back(bt(s_sh));
         if (s_bits == 9) begin
            trace.push_back(ak(sda_w));
            if (s_rd && sda_w) s_rd = 0;
         end
      end else if (!scl && scl_p) begin
         if (s_bits == 8) begin
            if (!s_rd) begin
               if (s_nbyte == 0) begin
                  s_on = present && s_sh[7:1] == 7'h53;
                  s_pend = s_on && s_sh[0];
               end else if (s_on && s_nbyte == 1) s_ptr = s_sh;
               else if (s_on) begin
                  mem[s_ptr] = s_sh;
                  s_ptr++;
               end
               s_nbyte++;
               s_drv = s_on;
            end else s_drv = 0;
         end else if (s_bits == 9) begin
            s_bits = 0;
            s_drv = 0;
            if (s_pend) begin s_rd = 1; s_pend = 0; end
            if (s_rd) begin
               s_tx = mem[s_ptr];
               s_ptr++;
               s_drv = !s_tx[7];
            end
         end else if (s_rd && s_bits >= 1 && s_bits <= 7) begin
            s_tx = s_tx << 1;
            s_drv = !s_tx[7];
         end
      end
      scl_p = scl;
      sda_p = sda_w;
   end

   // SCL high/low durations in clks; a high period containing a START is not a data bit
   int   run = 0, lo_bad = 0, hi_bad = 0, lo_n = 0, hi_n = 0;
   logic scl_m = 1, sda_m = 1, skip = 1, st_hi = 0;
   always @(posedge clk) begin
      if (rst) begin
         skip = 1;
         run = 0;
      end else if (scl !== scl_m) begin
         if (!skip && scl_m) begin
            hi_n++;
            if (!st_hi && run != 62) hi_bad++;
         end else if (!skip) begin
            lo_n++;
            if (run != 62) lo_bad++;
         end
         skip = 0;
         st_hi = 0;
         run = 1;
      end else run++;
      if (scl_m && scl && sda_m && !sda_w) st_hi = 1;
      scl_m = scl;
      sda_m = sda_w;
   end

   task automatic wait_ack(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 20000);
      chk({tag, "_ack_seen"}, 32'(ack), 1);
   endtask

   task automatic cmp_trace(input string tag);
      chk({tag, "_len"}, trace.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
         chk($sformatf("%s_tok%0d", tag, i), trace[i], exp_q[i]);
   endtask

   initial begin
      int a0, n;
      logic prev;
      repeat (3) @(negedge clk);
      chk("rst_scl", 32'(scl), 1);
      chk("rst_sda", 32'(sda_w), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_dout", data_out, 0);
      rst = 0;
      repeat (3) @(negedge clk);

      // abort mid-write: reset while the master drives bit 0 of 0x12 low
      ctrl_byte = 8'hA6; data_in = 32'h12345678; req = 1;
      @(negedge clk);
      req = 0;
      n = 0;
      while (trace.size() < 5 && n < 20000) begin @(negedge clk); n++; end
      prev = scl;
      n = 0;
      do begin prev = scl; @(negedge clk); n++; end while (!(!prev && scl) && n < 1000);
      chk("abort_busy_before", 32'(busy), 1);
      chk("abort_sda_low", 32'(sda_w), 0);
      rst = 1;
      #1;
      chk("abort_scl", 32'(scl), 1);
      chk("abort_sda", 32'(sda_w), 1);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ack", 32'(ack), 0);
      chk("abort_dout", data_out, 0);
      @(negedge clk);
      rst = 0;
      repeat (10) @(negedge clk);
      trace.delete();

      // page write, req held 3 clks
      a0 = ack_cnt;
      req = 1;
      repeat (3) @(negedge clk);
      req = 0;
      wait_ack("wr");
      chk("wr_busy_at_ack", 32'(busy), 0);
      repeat (5) @(negedge clk);
      chk("wr_ack_count", ack_cnt - a0, 1);
      chk("wr_idle_scl", 32'(scl), 1);
      chk("wr_idle_sda", 32'(sda_w), 1);
      exp_q = {TS, bt(8'hA6), ak(0), bt(8'h00), ak(0), bt(8'h12), ak(0), bt(8'h34), ak(0),
               bt(8'h56), ak(0), bt(8'h78), ak(0), TP};
      cmp_trace("wr");
      chk("mem0", 32'(mem[0]), 32'h12);
      chk("mem1", 32'(mem[1]), 32'h34);
      chk("mem2", 32'(mem[2]), 32'h56);
      chk("mem3", 32'(mem[3]), 32'h78);

      // random read with a stray req mid-transfer
      trace.delete();
      a0 = ack_cnt;
      ctrl_byte = 8'hA7; data_in = 32'hFFFFFFFF; req = 1;
      @(negedge clk);
      req = 0;
      repeat (2000) @(negedge clk);
      req = 1;
      @(negedge clk);
      req = 0;
      chk("rd_busy_mid", 32'(busy), 1);
      wait_ack("rd");
      chk("rd_dout_at_ack", data_out, 32'h12345678);
      chk("rd_busy_at_ack", 32'(busy), 0);
      repeat (200) @(negedge clk);
      chk("rd_ack_count", ack_cnt - a0, 1);
      chk("rd_busy_after", 32'(busy), 0);
      exp_q = {TS, bt(8'hA6), ak(0), bt(8'h00), ak(0), TS, bt(8'hA7), ak(0),
               bt(8'h12), ak(0), bt(8'h34), ak(0), bt(8'h56), ak(0), bt(8'h78), ak(1), TP};
      cmp_trace("rd");

      // no slave on the bus
      trace.delete();
      present = 0;
      a0 = ack_cnt;
      ctrl_byte = 8'hA6; data_in = 32'hDEADBEEF; req = 1;
      @(negedge clk);
      req = 0;
`ifdef EEPROM_I2C_CTRL_ACK_POLL_EN
      n = 0;
      while (trace.size() < 5 && n < 20000) begin @(negedge clk); n++; end
      chk("poll_restart", trace.size() >= 5 ? trace[4] : 32'h0, TS);
      chk("poll_busy", 32'(busy), 1);
      present = 1;
      wait_ack("poll");
      chk("poll_dout", data_out, 32'h12345678);
      chk("poll_mem0", 32'(mem[0]), 32'hDE);
`else
      wait_ack("ns");
      chk("ns_busy_at_ack", 32'(busy), 0);
      chk("ns_dout", data_out, 32'h12345678);
      repeat (5) @(negedge clk);
      chk("ns_ack_count", ack_cnt - a0, 1);
      exp_q = {TS, bt(8'hA6), ak(1), TP};
      cmp_trace("ns");
`endif

      chk("scl_low_time_bad", lo_bad, 0);
      chk("scl_high_time_bad", hi_bad, 0);
      chk("scl_periods_seen", 32'(lo_n > 100 && hi_n > 100), 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
